// File: rtl/rf_pkg.sv
// Shared types and sizes for the register-file write scheduler.
package rf_pkg;

   localparam int AW   = 5;
   localparam int DW   = 24;
   localparam int NREG = 32;

   typedef enum logic {
      REQ_ALU = 1'b0,
      REQ_MEM = 1'b1
   } req_e;

   typedef logic [AW-1:0] rf_addr_t;
   typedef logic [DW-1:0] rf_data_t;

endpackage

// File: rtl/rf_write_scheduler_if.sv
// Bundle of writeback requesters, decode claim/hazard signals and the
// register-file write port. master = environment side, slave = scheduler.
interface rf_write_scheduler_if;
   import rf_pkg::*;

   logic     alu_valid;
   rf_addr_t alu_wadd;
   rf_data_t alu_data;
   logic     alu_ready;

   logic     mem_valid;
   rf_addr_t mem_wadd;
   rf_data_t mem_data;
   logic     mem_ready;

   logic     issue_valid;
   rf_addr_t issue_wadd;
   logic     issue_stall;

   rf_addr_t radd1;
   rf_addr_t radd2;
   logic     hazard;

   rf_addr_t rf_wadd;
   rf_data_t rf_datain;
   logic     rf_wr;
   logic     wb_orphan;

   modport master (
      output alu_valid, alu_wadd, alu_data,
      output mem_valid, mem_wadd, mem_data,
      output issue_valid, issue_wadd,
      output radd1, radd2,
      input  alu_ready, mem_ready, issue_stall, hazard,
      input  rf_wadd, rf_datain, rf_wr, wb_orphan
   );

   modport slave (
      input  alu_valid, alu_wadd, alu_data,
      input  mem_valid, mem_wadd, mem_data,
      input  issue_valid, issue_wadd,
      input  radd1, radd2,
      output alu_ready, mem_ready, issue_stall, hazard,
      output rf_wadd, rf_datain, rf_wr, wb_orphan
   );

endinterface

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter. req[0]/gnt[0] = ALU, req[1]/gnt[1] = MEM.
// Only contended grants move the pointer; nothing is granted during reset.
module rr_arb2
   import rf_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   req_e last;
   req_e last_n;

   // Pointer register: winner of the most recent contended grant.
   always_ff @(posedge clk) begin
      if (rst) last <= REQ_ALU;
      else     last <= last_n;
   end

   // Next pointer: advance only when both requesters competed.
   always_comb begin
      last_n = last;
      if (!rst && req == 2'b11)
         last_n = gnt[1] ? REQ_MEM : REQ_ALU;
   end

   // Grant: lone requester wins, contention goes to whoever did not win last.
   always_comb begin
      gnt = 2'b00;
      if (!rst) begin
         if (req == 2'b11) gnt = (last == REQ_ALU) ? 2'b10 : 2'b01;
         else              gnt = req;
      end
   end

endmodule

// File: rtl/rf_write_scheduler.sv
// Write-port controller for the 32 x 24 register file: arbitrates ALU and
// load writebacks, tracks pending writes per register and reports hazards.
module rf_write_scheduler
   import rf_pkg::*;
(
   input logic                 clk,
   input logic                 rst,
   rf_write_scheduler_if.slave bus
);

   logic [1:0]      req;
   logic [1:0]      gnt;
   logic            acc;
   rf_addr_t        acc_wadd;
   rf_data_t        acc_data;
   logic            issue_ok;
   logic [NREG-1:0] busy_n;

   logic [NREG-1:0] busy_p1;
   logic            wr_p1;
   rf_addr_t        wadd_p1;
   rf_data_t        data_p1;
   logic            orphan_p1;

   assign req = {bus.mem_valid, bus.alu_valid};

   rr_arb2 u_arb (
      .clk (clk),
      .rst (rst),
      .req (req),
      .gnt (gnt)
   );

   assign bus.alu_ready = gnt[0];
   assign bus.mem_ready = gnt[1];

   // Select the granted writeback.
   always_comb begin
      acc      = |gnt;
      acc_wadd = gnt[1] ? bus.mem_wadd : bus.alu_wadd;
      acc_data = gnt[1] ? bus.mem_data : bus.alu_data;
   end

   // A claim is refused while a write to the same register is still pending,
   // so a second in-flight write can never be lost behind one busy bit.
   assign bus.issue_stall = bus.issue_valid && busy_p1[bus.issue_wadd];
   assign issue_ok        = bus.issue_valid && !bus.issue_stall;

   // Scoreboard update: clear on grant, then set on claim so a same-cycle set wins.
   always_comb begin
      busy_n = busy_p1;
      if (acc)      busy_n[acc_wadd]       = 1'b0;
      if (issue_ok) busy_n[bus.issue_wadd] = 1'b1;
   end

   // Scoreboard register.
   always_ff @(posedge clk) begin
      if (rst) busy_p1 <= '0;
      else     busy_p1 <= busy_n;
   end

   // Register-file write stage: address/data hold when nothing is granted.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_p1   <= 1'b0;
         wadd_p1 <= '0;
         data_p1 <= '0;
      end else begin
         wr_p1 <= acc;
         if (acc) begin
            wadd_p1 <= acc_wadd;
            data_p1 <= acc_data;
         end
      end
   end

   // Sticky flag for a write that arrives with no claim on its register.
   always_ff @(posedge clk) begin
      if (rst)                           orphan_p1 <= 1'b0;
      else if (acc && !busy_p1[acc_wadd]) orphan_p1 <= 1'b1;
   end

   // Hazard also covers the write cycle itself: the register file only
   // commits at the end of the cycle where rf_wr is high.
   always_comb begin
      bus.hazard = busy_p1[bus.radd1] || busy_p1[bus.radd2] ||
                   (wr_p1 && (wadd_p1 == bus.radd1 || wadd_p1 == bus.radd2));
   end

   assign bus.rf_wr     = wr_p1;
   assign bus.rf_wadd   = wadd_p1;
   assign bus.rf_datain = data_p1;
   assign bus.wb_orphan = orphan_p1;

endmodule

// File: tb/tb_rf_write_scheduler.sv
// Directed testbench for rf_write_scheduler.
module tb_rf_write_scheduler;
   import rf_pkg::*;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   rf_write_scheduler_if bus ();

   rf_write_scheduler dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.alu_valid   = 1'b0;
      bus.alu_wadd    = '0;
      bus.alu_data    = '0;
      bus.mem_valid   = 1'b0;
      bus.mem_wadd    = '0;
      bus.mem_data    = '0;
      bus.issue_valid = 1'b0;
      bus.issue_wadd  = '0;
      bus.radd1       = '0;
      bus.radd2       = '0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      #1;
      checks++;
      if (bus.rf_wr !== 1'b0) begin failures++; $display("FAIL reset_rf_wr got=%0b want=0", bus.rf_wr); end
      checks++;
      if (bus.hazard !== 1'b0) begin failures++; $display("FAIL reset_hazard got=%0b want=0", bus.hazard); end
      checks++;
      if (bus.wb_orphan !== 1'b0) begin failures++; $display("FAIL reset_orphan got=%0b want=0", bus.wb_orphan); end
      checks++;
      if (bus.rf_wadd !== 5'd0 || bus.rf_datain !== 24'd0) begin
         failures++; $display("FAIL reset_addr_data got=%0d/%h want=0/000000", bus.rf_wadd, bus.rf_datain);
      end
   endtask

   task automatic test_raw_hazard();
      step();
      bus.issue_valid = 1'b1;
      bus.issue_wadd  = 5'd5;
      step();
      bus.issue_valid = 1'b0;
      bus.radd1       = 5'd5;
      #1;
      checks++;
      if (bus.hazard !== 1'b1) begin failures++; $display("FAIL raw_hazard_pending got=%0b want=1", bus.hazard); end
      bus.alu_valid = 1'b1;
      bus.alu_wadd  = 5'd5;
      bus.alu_data  = 24'h00ABCD;
      #1;
      checks++;
      if (bus.alu_ready !== 1'b1) begin failures++; $display("FAIL raw_alu_ready got=%0b want=1", bus.alu_ready); end
      step();
      bus.alu_valid = 1'b0;
      #1;
      checks++;
      if (bus.rf_wr !== 1'b1 || bus.rf_wadd !== 5'd5 || bus.rf_datain !== 24'h00ABCD) begin
         failures++;
         $display("FAIL raw_write got=wr%0b/%0d/%h want=wr1/5/00abcd", bus.rf_wr, bus.rf_wadd, bus.rf_datain);
      end
      checks++;
      if (bus.hazard !== 1'b1) begin failures++; $display("FAIL raw_hazard_wr_cycle got=%0b want=1", bus.hazard); end
      step();
      checks++;
      if (bus.hazard !== 1'b0 || bus.rf_wr !== 1'b0) begin
         failures++; $display("FAIL raw_hazard_drop got=haz%0b/wr%0b want=haz0/wr0", bus.hazard, bus.rf_wr);
      end
      bus.radd1 = '0;
   endtask

   task automatic test_contention();
      logic [4:0]  aq [2];
      logic [23:0] ad [2];
      logic [4:0]  mq [2];
      logic [23:0] md [2];
      logic        exp_mem [4];
      logic [4:0]  exp_wadd [4];
      logic [23:0] exp_data [4];
      int ai;
      int mi;
      aq = '{5'd2, 5'd4};  ad = '{24'h000222, 24'h000444};
      mq = '{5'd1, 5'd3};  md = '{24'h000111, 24'h000333};
      exp_mem  = '{1'b1, 1'b0, 1'b1, 1'b0};
      exp_wadd = '{5'd1, 5'd2, 5'd3, 5'd4};
      exp_data = '{24'h000111, 24'h000222, 24'h000333, 24'h000444};
      ai = 0;
      mi = 0;
      for (int r = 1; r <= 4; r++) begin
         bus.issue_valid = 1'b1;
         bus.issue_wadd  = 5'(r);
         step();
      end
      bus.issue_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         bus.alu_valid = (ai < 2);
         if (ai < 2) begin bus.alu_wadd = aq[ai]; bus.alu_data = ad[ai]; end
         bus.mem_valid = (mi < 2);
         if (mi < 2) begin bus.mem_wadd = mq[mi]; bus.mem_data = md[mi]; end
         #1;
         checks++;
         if (bus.mem_ready !== exp_mem[k] || bus.alu_ready !== !exp_mem[k]) begin
            failures++;
            $display("FAIL rr_grant%0d got=mem%0b/alu%0b want=mem%0b/alu%0b", k, bus.mem_ready, bus.alu_ready, exp_mem[k], !exp_mem[k]);
         end
         if (k > 0) begin
            checks++;
            if (bus.rf_wr !== 1'b1 || bus.rf_wadd !== exp_wadd[k-1] || bus.rf_datain !== exp_data[k-1]) begin
               failures++;
               $display("FAIL rr_land%0d got=wr%0b/%0d/%h want=wr1/%0d/%h", k-1, bus.rf_wr, bus.rf_wadd, bus.rf_datain, exp_wadd[k-1], exp_data[k-1]);
            end
         end
         step();
         if (exp_mem[k]) mi++;
         else            ai++;
      end
      bus.alu_valid = 1'b0;
      bus.mem_valid = 1'b0;
      #1;
      checks++;
      if (bus.rf_wr !== 1'b1 || bus.rf_wadd !== exp_wadd[3] || bus.rf_datain !== exp_data[3]) begin
         failures++;
         $display("FAIL rr_land3 got=wr%0b/%0d/%h want=wr1/%0d/%h", bus.rf_wr, bus.rf_wadd, bus.rf_datain, exp_wadd[3], exp_data[3]);
      end
      step();
      bus.radd1 = 5'd1;
      bus.radd2 = 5'd4;
      #1;
      checks++;
      if (bus.hazard !== 1'b0 || bus.wb_orphan !== 1'b0) begin
         failures++; $display("FAIL rr_cleared got=haz%0b/orph%0b want=haz0/orph0", bus.hazard, bus.wb_orphan);
      end
      bus.radd1 = '0;
      bus.radd2 = '0;
   endtask

   task automatic test_waw_stall();
      bus.issue_valid = 1'b1;
      bus.issue_wadd  = 5'd7;
      #1;
      checks++;
      if (bus.issue_stall !== 1'b0) begin failures++; $display("FAIL waw_first_issue got=%0b want=0", bus.issue_stall); end
      step();
      checks++;
      if (bus.issue_stall !== 1'b1) begin failures++; $display("FAIL waw_second_issue got=%0b want=1", bus.issue_stall); end
      bus.issue_valid = 1'b0;
      bus.alu_valid   = 1'b1;
      bus.alu_wadd    = 5'd7;
      bus.alu_data    = 24'h777777;
      step();
      bus.alu_valid = 1'b0;
      #1;
      checks++;
      if (bus.rf_wr !== 1'b1 || bus.rf_wadd !== 5'd7 || bus.wb_orphan !== 1'b0) begin
         failures++; $display("FAIL waw_write got=wr%0b/%0d/orph%0b want=wr1/7/orph0", bus.rf_wr, bus.rf_wadd, bus.wb_orphan);
      end
      step();
   endtask

   task automatic test_orphan();
      bus.mem_valid = 1'b1;
      bus.mem_wadd  = 5'd9;
      bus.mem_data  = 24'h009999;
      #1;
      checks++;
      if (bus.mem_ready !== 1'b1 || bus.wb_orphan !== 1'b0) begin
         failures++; $display("FAIL orphan_accept got=rdy%0b/orph%0b want=rdy1/orph0", bus.mem_ready, bus.wb_orphan);
      end
      step();
      bus.mem_valid = 1'b0;
      #1;
      checks++;
      if (bus.rf_wr !== 1'b1 || bus.rf_wadd !== 5'd9 || bus.rf_datain !== 24'h009999 || bus.wb_orphan !== 1'b1) begin
         failures++;
         $display("FAIL orphan_write got=wr%0b/%0d/%h/orph%0b want=wr1/9/009999/orph1", bus.rf_wr, bus.rf_wadd, bus.rf_datain, bus.wb_orphan);
      end
      step();
      step();
      checks++;
      if (bus.wb_orphan !== 1'b1) begin failures++; $display("FAIL orphan_sticky got=%0b want=1", bus.wb_orphan); end
   endtask

   task automatic test_set_wins();
      bus.issue_valid = 1'b1;
      bus.issue_wadd  = 5'd7;
      bus.alu_valid   = 1'b1;
      bus.alu_wadd    = 5'd7;
      bus.alu_data    = 24'h070707;
      #1;
      checks++;
      if (bus.issue_stall !== 1'b0 || bus.alu_ready !== 1'b1) begin
         failures++; $display("FAIL setwins_same_cycle got=stall%0b/rdy%0b want=stall0/rdy1", bus.issue_stall, bus.alu_ready);
      end
      step();
      bus.issue_valid = 1'b0;
      bus.alu_valid   = 1'b0;
      step();
      bus.radd1 = 5'd0;
      bus.radd2 = 5'd7;
      #1;
      checks++;
      if (bus.hazard !== 1'b1 || bus.rf_wr !== 1'b0) begin
         failures++; $display("FAIL setwins_busy got=haz%0b/wr%0b want=haz1/wr0", bus.hazard, bus.rf_wr);
      end
      bus.issue_valid = 1'b1;
      bus.issue_wadd  = 5'd7;
      #1;
      checks++;
      if (bus.issue_stall !== 1'b1) begin failures++; $display("FAIL setwins_reissue got=%0b want=1", bus.issue_stall); end
      bus.issue_valid = 1'b0;
      bus.radd2       = '0;
      step();
   endtask

   task automatic test_reset_midflight();
      bus.issue_valid = 1'b1;
      bus.issue_wadd  = 5'd3;
      step();
      bus.issue_wadd  = 5'd4;
      step();
      bus.issue_valid = 1'b0;
      bus.alu_valid   = 1'b1;
      bus.alu_wadd    = 5'd3;
      bus.alu_data    = 24'h003333;
      step();
      bus.alu_valid = 1'b0;
      rst           = 1'b1;
      bus.mem_valid = 1'b1;
      bus.mem_wadd  = 5'd4;
      bus.mem_data  = 24'h004444;
      #1;
      checks++;
      if (bus.rf_wr !== 1'b1 || bus.mem_ready !== 1'b0) begin
         failures++; $display("FAIL rst_inflight got=wr%0b/rdy%0b want=wr1/rdy0", bus.rf_wr, bus.mem_ready);
      end
      step();
      rst           = 1'b0;
      bus.mem_valid = 1'b0;
      bus.radd1     = 5'd3;
      bus.radd2     = 5'd4;
      #1;
      checks++;
      if (bus.rf_wr !== 1'b0 || bus.hazard !== 1'b0) begin
         failures++; $display("FAIL rst_dropped got=wr%0b/haz%0b want=wr0/haz0", bus.rf_wr, bus.hazard);
      end
      checks++;
      if (bus.wb_orphan !== 1'b0 || bus.rf_wadd !== 5'd0) begin
         failures++; $display("FAIL rst_regs got=orph%0b/%0d want=orph0/0", bus.wb_orphan, bus.rf_wadd);
      end
      bus.radd1 = 5'd7;
      bus.radd2 = 5'd5;
      #1;
      checks++;
      if (bus.hazard !== 1'b0) begin failures++; $display("FAIL rst_busy7 got=%0b want=0", bus.hazard); end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      idle_inputs();
      test_reset();
      test_raw_hazard();
      test_contention();
      test_waw_stall();
      test_orphan();
      test_set_wins();
      test_reset_midflight();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
